wb_queue: RTL and testbench

- 4-entry in-order write-back buffer that owns the register-file write port (we3/wa3/wd3).
- Accepts completed results from execute/load units via a valid/ready push interface and drains one entry per cycle into the register file.
- Provides read-side forwarding of results still in flight, so decode readers see pending data before it is committed.

---
 rtl/wb_queue.sv | 106 ++++++++++
 tb/tb_wb_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Write-back queue: in-order buffer that owns the register-file write port,
// with read-side forwarding of results that have not yet been committed.
// Latency: accepted push is visible at an empty head the next cycle and is
// committed on the following edge when drain_en=1.
// Backpressure: push_ready = !full; no pass-through, so a full queue refuses
// pushes even in a cycle where it drains.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   push_valid/push_ready/addr/data    result push handshake
//   drain_en, we3/wa3/wd3              register-file write port
//   ra1/ra2, fwd1_*/fwd2_*             forwarding lookup for two readers
//   count, empty, full                 occupancy status
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [AW-1:0]                push_addr,
  input  logic [DW-1:0]                push_data,
  input  logic                         drain_en,
  output logic                         we3,
  output logic [AW-1:0]                wa3,
  output logic [DW-1:0]                wd3,
  input  logic [AW-1:0]                ra1,
  input  logic [AW-1:0]                ra2,
  output logic                         fwd1_hit,
  output logic [DW-1:0]                fwd1_data,
  output logic                         fwd2_hit,
  output logic [DW-1:0]                fwd2_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_fire;
  logic          pop;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign push_ready = !full;

  // Writes to r0 complete the handshake but are dropped: r0 is hardwired.
  assign push_fire = push_valid && push_ready && (push_addr != '0);
  assign pop       = we3;

  assign we3 = drain_en && !empty;
  assign wa3 = empty ? '0 : mem_addr[rd_ptr];
  assign wd3 = empty ? '0 : mem_data[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      case ({push_fire, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: validity comes from count and rd_ptr.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Walk entries oldest to youngest so the last match wins (youngest value).
  // Only the first count slots from rd_ptr hold live entries.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (ra1 != '0 && mem_addr[rd_ptr + PW'(k)] == ra1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = mem_data[rd_ptr + PW'(k)];
        end
        if (ra2 != '0 && mem_addr[rd_ptr + PW'(k)] == ra2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = mem_data[rd_ptr + PW'(k)];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          push_valid = 1'b0;
  logic          push_ready;
  logic [AW-1:0] push_addr = '0;
  logic [DW-1:0] push_data = '0;
  logic          drain_en = 1'b0;
  logic          we3;
  logic [AW-1:0] wa3;
  logic [DW-1:0] wd3;
  logic [AW-1:0] ra1 = '0;
  logic [AW-1:0] ra2 = '0;
  logic          fwd1_hit, fwd2_hit;
  logic [DW-1:0] fwd1_data, fwd2_data;
  logic [2:0]    count;
  logic          empty, full;

  int total = 0;
  int bad   = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_addr(push_addr), .push_data(push_data),
    .drain_en(drain_en), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sb holds live entries oldest-first. Inputs change only
  // just after posedge, so values seen at negedge are what the next edge uses.
  always @(negedge clk) begin
    int   n;
    logic e_we, e_rdy, h1, h2;
    logic [DW-1:0] d1, d2;
    ent_t hd;
    n     = sb.size();
    e_rdy = (n < DEPTH);
    e_we  = drain_en && (n > 0);
    hd    = (n > 0) ? sb[0] : '0;
    h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
    for (int i = 0; i < n; i++) begin
      if (ra1 != 0 && sb[i].a == ra1) begin h1 = 1'b1; d1 = sb[i].d; end
      if (ra2 != 0 && sb[i].a == ra2) begin h2 = 1'b1; d2 = sb[i].d; end
    end
    check_eq("count", count, n);
    check_eq("empty", empty, n == 0);
    check_eq("full", full, n == DEPTH);
    check_eq("push_ready", push_ready, e_rdy);
    check_eq("we3", we3, e_we);
    check_eq("wa3", wa3, hd.a);
    check_eq("wd3", wd3, hd.d);
    check_eq("fwd1_hit", fwd1_hit, h1);
    check_eq("fwd1_data", fwd1_data, d1);
    check_eq("fwd2_hit", fwd2_hit, h2);
    check_eq("fwd2_data", fwd2_data, d2);
    if (reset_n) begin
      if (e_we) void'(sb.pop_front());
      if (push_valid && e_rdy && push_addr != 0) sb.push_back({push_addr, push_data});
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic done;
    done = 1'b0;
    push_valid = 1'b1; push_addr = a; push_data = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (push_ready) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (done) begin @(posedge clk); #1; end
    push_valid = 1'b0;
    check_eq("push_accept", done, 1'b1);
  endtask

  task automatic wait_empty();
    drain_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && empty) break;
      @(posedge clk); #1;
    end
    check_eq("drained", sb.size() == 0 && empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_ready", push_ready, 1);
    check_eq("rst_we3", we3, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single push with drain enabled: visible next cycle, committed on edge after
    drain_en = 1'b1;
    push(5'd5, 32'hDEADBEEF);
    check_eq("t1_we3", we3, 1);
    check_eq("t1_wa3", wa3, 5);
    check_eq("t1_wd3", wd3, 32'hDEADBEEF);
    check_eq("t1_count", count, 1);
    @(posedge clk); #1;
    check_eq("t1_empty", empty, 1);
    check_eq("t1_we3_off", we3, 0);

    // Fill to full, hold a 5th push, then drain
    drain_en = 1'b0;
    for (int i = 1; i <= 4; i++) push(AW'(i), DW'(i));
    check_eq("t2_full", full, 1);
    check_eq("t2_ready", push_ready, 0);
    check_eq("t2_count", count, 4);
    push_valid = 1'b1; push_addr = 5'd6; push_data = 32'h66;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("t2_held", count, 4);
    drain_en = 1'b1;
    push(5'd6, 32'h66);
    wait_empty();

    // Forwarding: youngest of two pending writes to r7
    drain_en = 1'b0; ra1 = 5'd7; ra2 = 5'd0;
    push(5'd7, 32'h11);
    push(5'd7, 32'h22);
    check_eq("t3_hit", fwd1_hit, 1);
    check_eq("t3_data", fwd1_data, 32'h22);
    check_eq("t3_hit2", fwd2_hit, 0);
    drain_en = 1'b1; @(posedge clk); #1; drain_en = 1'b0;
    check_eq("t3_hit_a", fwd1_hit, 1);
    check_eq("t3_data_a", fwd1_data, 32'h22);
    drain_en = 1'b1; @(posedge clk); #1; drain_en = 1'b0;
    check_eq("t3_hit_b", fwd1_hit, 0);
    ra1 = 5'd0;

    // Simultaneous push and pop at count=3, pointers wrap
    push(5'd10, 32'hA0);
    push(5'd11, 32'hB0);
    push(5'd12, 32'hC0);
    check_eq("t4_count3", count, 3);
    drain_en = 1'b1; ra2 = 5'd9;
    push(5'd9, 32'h99);
    check_eq("t4_count", count, 3);
    check_eq("t4_fwd", fwd2_data, 32'h99);
    wait_empty();
    ra2 = 5'd0;

    // Push to r0 is swallowed
    push(5'd0, 32'hFFFF);
    check_eq("t5_count", count, 0);
    check_eq("t5_we3", we3, 0);
    @(posedge clk); #1;

    // Async reset with entries pending
    drain_en = 1'b0; ra1 = 5'd13; ra2 = 5'd14;
    push(5'd13, 32'h1);
    push(5'd14, 32'h2);
    push(5'd15, 32'h3);
    check_eq("t6_pre", count, 3);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check_eq("t6_count", count, 0);
    check_eq("t6_empty", empty, 1);
    check_eq("t6_we3", we3, 0);
    check_eq("t6_hit1", fwd1_hit, 0);
    check_eq("t6_hit2", fwd2_hit, 0);
    @(posedge clk); #1;
    reset_n = 1'b1; ra1 = 5'd0; ra2 = 5'd0;
    @(posedge clk); #1;
    drain_en = 1'b1;
    push(5'd2, 32'h5);
    check_eq("t6_wa3", wa3, 2);
    check_eq("t6_wd3", wd3, 32'h5);
    wait_empty();

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
